clock_run_ctrl: RTL and testbench
=================================

Name: clock_run_ctrl

Overview:
Sits directly downstream of the clock divider. Samples the divider's slow clock output in the fast `clk` domain and turns each of its rising edges into a one-`clk`-cycle CPU enable strobe (`cpu_en`). Gates those strobes by operator controls: free-run switch, single-step button, CPU halt. Provides a retired-step counter for the board display.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive identical synchronized samples required before a debounced input changes (bench overrides to 4)
CNT_WIDTH, 32, width of cycle_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
div_clock  input  1  slow clock from the divider, asynchronous to clk phase, treated as data
run_sw  input  1  raw run/stop slide switch, 1 = run
step_btn  input  1  raw single-step push button, 1 = pressed
halt_in  input  1  CPU halt indication, level
cpu_en  output  1  one-clk-cycle enable strobe to CPU datapath
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STEP_WAIT, 3 HALTED
run_led  output  1  high while state == RUN
cycle_count  output  CNT_WIDTH  number of cpu_en strobes issued since reset

Behaviour:
- Reset (sampled at a clk edge with reset=1):
  - cpu_en=0, state=IDLE, run_led=0, cycle_count=0.
  - All synchronizer, edge and debounce registers = 0; debounce counters = 0.
  - Reset asserted mid-operation aborts any pending step or run, with no further strobe.
- Synchronization: div_clock, run_sw and step_btn each pass through a 2-flop synchronizer.
- Tick detection:
  - tick = sync_div & ~prev_div, where prev_div is a register fed by sync_div.
  - tick is high for exactly one cycle per div_clock rising edge.
  - div_clock falling edges produce nothing.
- Debounce (run_sw, step_btn), per input:
  - Counter resets to 0 whenever the synchronized sample equals the current debounced value.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced value toggles and the counter clears.
  - step_press = one-cycle pulse on the debounced step rising edge.
- cpu_en is registered: high in the cycle after the FSM decides to strobe.
  - Latency: div_clock rise first sampled at edge k → cpu_en high from edge k+3 to edge k+4.
- FSM, evaluated every clk edge; halt_in has highest priority in every non-HALTED state:
  - IDLE: halt_in → HALTED. Else run_db=1 → RUN. Else step_press → STEP_WAIT. No strobes.
  - RUN:
    - halt_in → HALTED, no strobe, even if tick is high in the same cycle.
    - Else tick → strobe.
    - run_db=0 → IDLE; a tick in that same cycle still strobes.
    - step_press is ignored.
  - STEP_WAIT: halt_in → HALTED, no strobe. Else on tick: strobe once, → IDLE. Further step_press is ignored. run_db is ignored until IDLE.
  - HALTED: no strobes. Leaves only via reset.
- cycle_count increments by 1 in the cycle cpu_en is high. Wraps from all-ones to 0 with no flag.
- run_led and state are registered FSM outputs, updated on the same edge as the state register.

Decomposition:
- Package clock_ctrl_pkg holds:
  - the 2-bit state encodings ST_IDLE=0, ST_RUN=1, ST_STEP_WAIT=2, ST_HALTED=3;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module, `debounce`, contains the synchronizer, counter, debounced output and rising-edge pulse. Parameter DEBOUNCE_CYCLES. Instantiated twice (run_sw, step_btn).
- Tick detection and the FSM stay in clock_run_ctrl.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4; clk period 20 ns; div_clock driven as a square wave of 10 clk cycles period (5 high / 5 low).
- Reset: hold reset 3 cycles with div_clock toggling → cpu_en=0, state=0, cycle_count=0 throughout; no strobe on the first cycle after release.
- Free run: run_sw=1 held for 60 clk cycles → state=1 within 7 cycles, run_led=1; one cpu_en pulse, exactly 1 cycle wide, per div_clock rise, 3 edges after it. Set run_sw=0 → state=0; cycle_count equals the pulse count (≈5).
- Single step: from IDLE, press step_btn for 8 cycles, twice, with a 30-cycle gap → exactly 2 cpu_en pulses, each aligned to the next div_clock rise; state returns to 0 after each; cycle_count=2.
- Bounce rejection: step_btn toggling every 2 cycles for 20 cycles, then released → no step_press, no cpu_en, state stays 0.
- Halt priority: in RUN, assert halt_in on the cycle a tick occurs → no cpu_en that cycle, state=3. Toggle run_sw and step_btn afterwards → still 3, count frozen. Then reset → state=0.
- Counter wrap: CNT_WIDTH=4, free run for 17 strobes → cycle_count sequence …14, 15, 0, 1.

Source files
------------

// File: rtl/clock_run_ctrl_pkg.sv
// Shared constants for the clock run controller: FSM state encodings and
// the default debounce length.
package clock_ctrl_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STEP_WAIT = 2'd2;
  localparam logic [1:0] ST_HALTED    = 2'd3;

  localparam int DEBOUNCE_CYCLES_DEF = 1000;

endpackage

// File: rtl/clock_run_ctrl_debounce.sv
// Two-flop synchronizer plus counter debounce for a raw operator input,
// with a one-cycle pulse on each debounced rising edge.
module debounce
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      level_q <= level;
      // any sample agreeing with the current level restarts the qualification
      if (sync_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/clock_run_ctrl.sv
// Turns divider clock rising edges into single-cycle CPU enable strobes,
// gated by run switch, single-step button and CPU halt.
//
// state        | meaning
// IDLE         | stopped, waiting for run switch or step press
// RUN          | free run, one strobe per divider tick
// STEP_WAIT    | step requested, strobe once on the next tick
// HALTED       | CPU halted, no strobes until reset
module clock_run_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 div_clock,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 halt_in,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic                 run_led,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  logic [1:0] div_sync;
  logic       prev_div;
  logic       tick;
  logic       tick_q;
  logic       run_db;
  logic       unused_run_rise;
  logic       step_db_unused;
  logic       step_press;
  logic [1:0] next_state;
  logic       strobe;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .raw   (run_sw),
    .level (run_db),
    .rise  (unused_run_rise)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .level (step_db_unused),
    .rise  (step_press)
  );

  assign tick = div_sync[1] & ~prev_div;

  // tick is retimed once so the strobe lands three edges after the divider
  // rise is first sampled
  always_ff @(posedge clk) begin
    if (reset) begin
      div_sync <= 2'b00;
      prev_div <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_sync <= {div_sync[0], div_clock};
      prev_div <= div_sync[1];
      tick_q   <= tick;
    end
  end

  always_comb begin
    next_state = state;
    strobe     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (halt_in)         next_state = ST_HALTED;
        else if (run_db)     next_state = ST_RUN;
        else if (step_press) next_state = ST_STEP_WAIT;
      end
      ST_RUN: begin
        if (halt_in) begin
          next_state = ST_HALTED;
        end else begin
          strobe = tick_q;
          if (!run_db) next_state = ST_IDLE;
        end
      end
      ST_STEP_WAIT: begin
        if (halt_in) begin
          next_state = ST_HALTED;
        end else if (tick_q) begin
          strobe     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      run_led     <= 1'b0;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state   <= next_state;
      run_led <= (next_state == ST_RUN);
      cpu_en  <= strobe;
      if (cpu_en) cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Directed and randomized bench for clock_run_ctrl against an edge-history
// reference model.
module tb_clock_run_ctrl;

  localparam int DB   = 4;
  localparam int CW   = 4;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          reset, div_clock, run_sw, step_btn, halt_in;
  logic          cpu_en, run_led;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  clock_run_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .div_clock   (div_clock),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .halt_in     (halt_in),
    .cpu_en      (cpu_en),
    .state       (state),
    .run_led     (run_led),
    .cycle_count (cycle_count)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // raw input values captured at each clk edge: 0 div, 1 run, 2 step
  logic hist [3][HMAX];
  int   n = 0;
  int   last_rst = -1;
  int   div_phase = 3;
  int   pulses = 0;

  // reference model state, as seen just after the latest edge
  bit m_run_db, m_step_db, m_step_db_d, m_en;
  int m_run_streak, m_step_streak, m_mode, m_count;

  int cnt_seq[$];

  function automatic logic s_at(input int sel, input int x);
    if (x < 0 || x <= last_rst) return 1'b0;
    return hist[sel][x];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int e, input logic rst, input logic halt);
    bit tq, sr, ss, press, run_pre, en_pre, strobe;
    if (rst) begin
      last_rst = e;
      m_run_db = 0; m_step_db = 0; m_step_db_d = 0; m_en = 0;
      m_run_streak = 0; m_step_streak = 0; m_mode = 0; m_count = 0;
      return;
    end
    tq      = s_at(0, e - 3) & ~s_at(0, e - 4);
    sr      = s_at(1, e - 2);
    ss      = s_at(2, e - 2);
    press   = m_step_db & ~m_step_db_d;
    run_pre = m_run_db;
    en_pre  = m_en;
    strobe  = 0;
    case (m_mode)
      0: if (halt) m_mode = 3; else if (run_pre) m_mode = 1; else if (press) m_mode = 2;
      1: if (halt) m_mode = 3; else begin strobe = tq; if (!run_pre) m_mode = 0; end
      2: if (halt) m_mode = 3; else if (tq) begin strobe = 1; m_mode = 0; end
      default: ;
    endcase
    m_en = strobe;
    if (en_pre) m_count = (m_count + 1) % (1 << CW);
    m_step_db_d = m_step_db;
    if (sr != m_run_db) begin
      m_run_streak++;
      if (m_run_streak == DB) begin m_run_db = ~m_run_db; m_run_streak = 0; end
    end else m_run_streak = 0;
    if (ss != m_step_db) begin
      m_step_streak++;
      if (m_step_streak == DB) begin m_step_db = ~m_step_db; m_step_streak = 0; end
    end else m_step_streak = 0;
  endtask

  // predicted retimed tick at the coming edge, from input history only
  function automatic bit tick_next();
    return s_at(0, n - 3) & ~s_at(0, n - 4);
  endfunction

  task automatic cycle();
    if (n >= HMAX) begin
      $display("FAIL history_overflow: observed %0d edges expected below %0d", n, HMAX);
      $fatal(1, "edge budget exhausted");
    end
    div_clock = ((div_phase % 10) >= 5);
    @(posedge clk);
    hist[0][n] = div_clock;
    hist[1][n] = run_sw;
    hist[2][n] = step_btn;
    model_edge(n, reset, halt_in);
    n++;
    div_phase++;
    @(negedge clk);
    chk("cpu_en", cpu_en, m_en);
    chk("state", state, m_mode);
    chk("run_led", run_led, (m_mode == 1));
    chk("cycle_count", cycle_count, m_count);
    if (cpu_en === 1'b1) pulses++;
    if (cnt_seq.size() == 0 || cnt_seq[$] != int'(cycle_count)) cnt_seq.push_back(int'(cycle_count));
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    cycles(k);
    reset = 1'b0;
  endtask

  initial begin
    int p0, frozen, len;
    bit seen;
    reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_in = 1'b0; div_clock = 1'b0;

    // reset held three cycles with the divider toggling
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_cpu_en", cpu_en, 1'b0);
      chk("rst_state", state, 2'd0);
      chk("rst_count", cycle_count, 4'd0);
    end
    reset = 1'b0;
    cycle();
    chk("post_rst_cpu_en", cpu_en, 1'b0);
    cycles(12);

    // free run
    run_sw = 1'b1;
    p0 = pulses;
    seen = 0;
    for (int i = 0; i < 7 && !seen; i++) begin
      cycle();
      if (state === 2'd1) seen = 1;
    end
    chk("run_within_7", seen, 1'b1);
    chk("run_led_on", run_led, 1'b1);
    cycles(53);
    run_sw = 1'b0;
    cycles(12);
    chk("run_stop_state", state, 2'd0);
    chk("run_pulses_vs_count", cycle_count, 4'((pulses - p0) % 16));
    chk("run_pulses_vs_model", pulses - p0, m_count);

    // single step, twice
    do_reset(2);
    p0 = pulses;
    for (int k = 0; k < 2; k++) begin
      step_btn = 1'b1;
      cycles(8);
      step_btn = 1'b0;
      cycles(30);
      chk("step_idle", state, 2'd0);
    end
    chk("step_pulses", pulses - p0, 2);
    chk("step_count", cycle_count, 4'd2);

    // bounce rejection
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      cycles(2);
    end
    step_btn = 1'b0;
    cycles(15);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_state", state, 2'd0);

    // halt on the same cycle as a tick
    run_sw = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (m_mode == 1 && state === 2'd1 && tick_next()) seen = 1;
      else cycle();
    end
    chk("halt_setup_reached", seen, 1'b1);
    halt_in = 1'b1;
    cycle();
    chk("halt_no_strobe", cpu_en, 1'b0);
    chk("halt_state", state, 2'd3);
    frozen = m_count;
    halt_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_sw = ~run_sw;
      step_btn = ~step_btn;
      cycles(8);
    end
    chk("halt_sticky", state, 2'd3);
    chk("halt_count_frozen", cycle_count, 4'(frozen));
    run_sw = 1'b0; step_btn = 1'b0;
    do_reset(1);
    chk("halt_reset_state", state, 2'd0);

    // counter wrap over 17 strobes
    cycles(8);
    cnt_seq.delete();
    run_sw = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 400 && (pulses - p0) < 17; i++) cycle();
    chk("wrap_strobes", pulses - p0, 17);
    cycles(2);
    chk("wrap_seq_len", (cnt_seq.size() >= 4), 1'b1);
    if (cnt_seq.size() >= 4) begin
      chk("wrap_seq_14", cnt_seq[cnt_seq.size() - 4], 14);
      chk("wrap_seq_15", cnt_seq[cnt_seq.size() - 3], 15);
      chk("wrap_seq_0",  cnt_seq[cnt_seq.size() - 2], 0);
      chk("wrap_seq_1",  cnt_seq[cnt_seq.size() - 1], 1);
    end
    run_sw = 1'b0;
    cycles(10);

    // randomized operator activity
    for (int seg = 0; seg < 40; seg++) begin
      run_sw   = 1'($urandom_range(0, 1));
      step_btn = 1'($urandom_range(0, 1));
      halt_in  = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 14) == 0);
      len      = $urandom_range(3, 25);
      cycle();
      reset = 1'b0;
      cycles(len);
      halt_in = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
